ahbl_irq_ctrl: RTL
==================

AHBL_IRQ_CTRL -- requirements
Module: ahbl_irq_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: NSRC, 8, number of interrupt sources (1..8).
REQ-003 Port: HCLK  in  1  system clock; all state updates on its rising edge.
REQ-004 Port: HRESET  in  1  synchronous active-high reset.
REQ-005 Ports: HADDR in 32, HTRANS in 2, HSIZE in 3, HWRITE in 1, HREADY in 1, HSEL in 1, HWDATA in 32; these are the AHB-Lite slave request inputs.
REQ-006 Ports: HREADYOUT out 1, HRDATA out 32; these are the AHB-Lite slave response outputs.
REQ-007 Port: IRQ_SRC  in  NSRC  peripheral interrupt lines; I2S IRQ is bit 0.
REQ-008 Port: IRQ  out  1  aggregated request to the CPU IRQ input.

Function
REQ-009 Address phase SHALL be latched when HSEL & HREADY & HTRANS[1]; the latch holds HADDR[4:2] and HWRITE, and the data phase follows in the next cycle.
REQ-010 HREADYOUT SHALL be constant 1, giving zero wait states.
REQ-011 HSIZE SHALL be ignored; every write is a word write.
REQ-012 Register map (word offsets):
  - 0x00 CTRL: bit0 GEN, global enable; RW.
  - 0x04 ENABLE[NSRC-1:0]: RW.
  - 0x08 TYPE[NSRC-1:0]: 1 = edge, 0 = level; RW.
  - 0x0C PENDING: read gives pending; write-1-to-clear applies to edge bits only.
  - 0x10 CLAIM: RO.
  - Other offsets SHALL read 0 and ignore writes.
REQ-013 HRDATA SHALL be combinational from the latched offset during the data phase; unused bits read 0.
REQ-014 Edge source i: pending[i] SHALL set at the clock edge where s[i]=1 and s_q[i]=0 (s = sampled input, s_q = its 1-cycle delay).
REQ-015 Level source i: pending[i] SHALL equal s[i] each cycle, registered.
REQ-016 IRQ SHALL be combinational: GEN & |(pending & ENABLE).
  - Latency: an edge sampled at clock k gives IRQ high in cycle k+1.
REQ-017 CLAIM read data SHALL be {28'b0, valid, idx[2:0]}.
  - idx is the lowest-numbered source with pending & ENABLE set.
  - valid=0 with data 0 when no such source exists.
REQ-018 A CLAIM read with valid=1 SHALL clear pending[idx] at the end of that data phase if idx is edge type; level sources are unaffected.
REQ-019 Simultaneous set and clear (W1C or claim) on the same bit SHALL resolve as set wins.
REQ-020 A TYPE change SHALL take effect next cycle.
  - Switching level to edge clears nothing.
  - Switching edge to level makes pending follow the input from then on.
REQ-021 ENABLE=0 SHALL NOT block pending capture; it masks only IRQ and CLAIM.

Reset
REQ-022 On HRESET (synchronous, active-high):
  - CTRL=0, ENABLE=0, TYPE=all 1s, pending=0, s_q=0.
  - Address-phase latch invalid, so a pending data phase is discarded.
  - IRQ=0, HRDATA=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no register side effect; an edge present during reset SHALL NOT be captured.

Configuration
REQ-024 Macro IRQ_CTRL_SYNC_EN:
  - Defined: each IRQ_SRC bit SHALL pass through a 2-flop synchronizer before s, adding 2 cycles to the REQ-016 latency (IRQ high in cycle k+3 after input rise at k).
  - Undefined: s = IRQ_SRC directly.

Structure
REQ-025 Package ahbl_irq_ctrl_pkg SHALL hold:
  - register offset constants (CTRL, ENABLE, TYPE, PENDING, CLAIM);
  - NSRC maximum;
  - CLAIM field positions.
REQ-026 Sub-module irq_prio_enc (combinational, NSRC in, valid + 3-bit idx out) SHALL implement the lowest-index-wins priority encoder.
REQ-027 SoC integration: I2S IRQ connects to IRQ_SRC[0], IRQ drives the CPU IRQ, and HSEL comes from a new splitter slot at 0x9000_0000.

Verification
REQ-028 The bench SHALL cover these directed scenarios (sync macro undefined unless stated):
  - After reset, all regs read per REQ-022; write ENABLE=0xFF, CTRL=1; IRQ stays 0 with no inputs.
  - ENABLE=0x05, GEN=1, pulse IRQ_SRC[2] for 1 cycle at k -> IRQ=1 at k+1; CLAIM reads 0xA; next CLAIM reads 0x0; IRQ=0.
  - Pending 0x06 with ENABLE=0x06 -> CLAIM returns 0x9, then 0xA, then 0x0.
  - TYPE[3]=0, IRQ_SRC[3] held high -> CLAIM returns 0xB repeatedly; drop input -> pending[3]=0 next cycle and IRQ=0.
  - W1C of 0x01 to PENDING in the same cycle as a new rising edge on IRQ_SRC[0] -> pending[0] remains 1.
  - IRQ_CTRL_SYNC_EN defined: input rises at k -> IRQ=1 at k+3; HRESET asserted at k+1 -> IRQ=0 and pending=0 after reset.

Source files
------------

// File: rtl/ahbl_irq_ctrl_pkg.sv
// Shared register map, claim-word layout and address-phase latch type for
// the AHB-Lite interrupt controller.
package ahbl_irq_ctrl_pkg;

  localparam int NSRC_MAX = 8;
  localparam int IDX_W    = 3;

  // Word offsets, i.e. HADDR[4:2]
  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_TYPE    = 3'd2;
  localparam logic [2:0] OFF_PENDING = 3'd3;
  localparam logic [2:0] OFF_CLAIM   = 3'd4;

  localparam int CLAIM_IDX_LSB   = 0;
  localparam int CLAIM_VALID_BIT = 3;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] off;
  } aphase_t;

  function automatic logic [31:0] claim_word(input logic valid, input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    w[CLAIM_VALID_BIT] = valid;
    w[CLAIM_IDX_LSB +: IDX_W] = valid ? idx : '0;
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the lowest-numbered active request wins.
module irq_prio_enc
  import ahbl_irq_ctrl_pkg::*;
#(
  parameter int NSRC = NSRC_MAX
) (
  input  logic [NSRC-1:0]  req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scanning downwards lets the last hit, the lowest index, stick.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ahbl_irq_ctrl.sv
// AHB-Lite interrupt controller with edge/level sources, W1C pending and claim.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on every IRQ_SRC line.
module ahbl_irq_ctrl
  import ahbl_irq_ctrl_pkg::*;
#(
  parameter int NSRC = NSRC_MAX
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic [2:0]      HSIZE,
  input  logic            HWRITE,
  input  logic            HREADY,
  input  logic            HSEL,
  input  logic [31:0]     HWDATA,
  output logic            HREADYOUT,
  output logic [31:0]     HRDATA,
  input  logic [NSRC-1:0] IRQ_SRC,
  output logic            IRQ
);

  logic [NSRC-1:0]  s, s_q;
  logic             ctrl_q;
  logic [NSRC-1:0]  enable_q, type_q, pending_q, pending_d;
  logic [NSRC-1:0]  rise, clr, w1c_mask;
  aphase_t          aph_q, aph_d;
  logic             wr_dp, rd_dp, claim_valid, claim_clr;
  logic [IDX_W-1:0] claim_idx;
  logic             unused_ok;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= IRQ_SRC;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = IRQ_SRC;
`endif

  assign aph_d = {HSEL & HREADY & HTRANS[1], HWRITE, HADDR[4:2]};
  assign wr_dp = aph_q.valid & aph_q.write;
  assign rd_dp = aph_q.valid & ~aph_q.write;

  irq_prio_enc #(.NSRC(NSRC)) u_enc (
    .req_i   (pending_q & enable_q),
    .valid_o (claim_valid),
    .idx_o   (claim_idx)
  );

  assign w1c_mask  = (wr_dp && aph_q.off == OFF_PENDING) ? HWDATA[NSRC-1:0] : '0;
  assign claim_clr = rd_dp && aph_q.off == OFF_CLAIM && claim_valid;

  // Edge bits: a fresh rise beats any clear in the same cycle. Level bits track s.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign rise[gi]      = s[gi] & ~s_q[gi];
    assign clr[gi]       = w1c_mask[gi] | (claim_clr & (claim_idx == IDX_W'(gi)));
    assign pending_d[gi] = type_q[gi] ? (rise[gi] | (pending_q[gi] & ~clr[gi])) : s[gi];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aph_q     <= '0;
      ctrl_q    <= 1'b0;
      enable_q  <= '0;
      type_q    <= '1;
      pending_q <= '0;
      s_q       <= '0;
    end else begin
      aph_q     <= aph_d;
      s_q       <= s;
      pending_q <= pending_d;
      if (wr_dp) begin
        case (aph_q.off)
          OFF_CTRL:   ctrl_q   <= HWDATA[0];
          OFF_ENABLE: enable_q <= HWDATA[NSRC-1:0];
          OFF_TYPE:   type_q   <= HWDATA[NSRC-1:0];
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_dp) begin
      case (aph_q.off)
        OFF_CTRL:    HRDATA[0]        = ctrl_q;
        OFF_ENABLE:  HRDATA[NSRC-1:0] = enable_q;
        OFF_TYPE:    HRDATA[NSRC-1:0] = type_q;
        OFF_PENDING: HRDATA[NSRC-1:0] = pending_q;
        OFF_CLAIM:   HRDATA           = claim_word(claim_valid, claim_idx);
        default:     HRDATA           = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign IRQ       = ctrl_q & (|(pending_q & enable_q));

  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[31:5], HADDR[1:0], HWDATA[31:NSRC]};

endmodule
